// File: rtl/seg_scan_ctrl_if.sv
// Display-side signal bundle for seg_scan_ctrl: value load/blanking control in,
// segment/anode drive and status out.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] din;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_pend;
  logic        frame_done;

  modport master (
    output load, din, blank_lz,
    input  seg, an, upd_pend, frame_done
  );

  modport slave (
    input  load, din, blank_lz,
    output seg, an, upd_pend, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous value
// updates, leading-zero blanking and invalid-BCD blanking.
module bcd_7_seg (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  // Active-high segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg_o = '0;
    case (bcd_i)
      4'd0:    seg_o = 7'h3F;
      4'd1:    seg_o = 7'h06;
      4'd2:    seg_o = 7'h5B;
      4'd3:    seg_o = 7'h4F;
      4'd4:    seg_o = 7'h66;
      4'd5:    seg_o = 7'h6D;
      4'd6:    seg_o = 7'h7D;
      4'd7:    seg_o = 7'h07;
      4'd8:    seg_o = 7'h7F;
      4'd9:    seg_o = 7'h6F;
      default: seg_o = '0;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int unsigned   CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {ST_IDLE, ST_PEND} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pend_q, pend_d;
  logic          tick;
  logic          frame_done;
  logic [3:0]    blank;
  logic [3:0]    cur_nib;
  logic [6:0]    seg_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    tick       = (div_cnt_q == DIV_LAST);
    div_cnt_d  = tick ? '0 : div_cnt_q + CW'(1);
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    frame_done = tick && (idx_q == 2'd3);
  end

  // A load coinciding with the frame boundary bypasses the pending register
  // and supersedes whatever was waiting there.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    active_d = active_q;
    if (frame_done) begin
      if (bus.load) begin
        active_d = bus.din;
      end else if (state_q == ST_PEND) begin
        active_d = pend_q;
      end
      state_d = ST_IDLE;
    end else if (bus.load) begin
      pend_d  = bus.din;
      state_d = ST_PEND;
    end
  end

  always_comb begin
    blank[0] = (active_q[3:0] > 4'd9);
    blank[1] = (active_q[7:4] > 4'd9)   || (bus.blank_lz && (active_q[15:4] == '0));
    blank[2] = (active_q[11:8] > 4'd9)  || (bus.blank_lz && (active_q[15:8] == '0));
    blank[3] = (active_q[15:12] > 4'd9) || (bus.blank_lz && (active_q[15:12] == '0));
    cur_nib  = active_q[{idx_q, 2'b00} +: 4];
  end

  bcd_7_seg u_dec (
    .bcd_i (cur_nib),
    .seg_o (seg_w)
  );

  assign bus.seg        = seg_w;
  assign bus.an         = blank[idx_q] ? 4'b1111 : ~(4'b0001 << idx_q);
  assign bus.upd_pend   = (state_q == ST_PEND);
  assign bus.frame_done = frame_done;
endmodule
